hiscore_ram_arbiter: RTL and testbench

- Shares the game work-RAM port between the game CPU and the hiscore load/save engine.
- When the hiscore engine requests access, the block pauses the CPU (optionally only in vblank), waits a settle time, then grants the port.
- Forwards hiscore reads and writes, then releases the CPU.
- Sits between the CPU RAM bus, the hiscore engine and the work-RAM instance in the core top level.

---
 rtl/hiscore_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter: pauses the CPU, waits SETTLE cycles, then hands the port to the hiscore engine.
// All outputs registered (1-cycle RAM mux latency); hs_rvalid lines up with ram_q of a 1-cycle RAM.
module hiscore_ram_arbiter #(
  parameter int AW         = 12,
  parameter int SETTLE     = 4,
  parameter int MAX_GRANT  = 256,
  parameter int USE_VBLANK = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vblank,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_dout,
  input  logic          hs_we,
  input  logic          hs_rd,
  output logic          hs_gnt,
  output logic          hs_rvalid,
  output logic          hs_abort,
  output logic          pause_cpu,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int WW = $clog2(MAX_GRANT + 1);

  typedef enum logic [1:0] {IDLE, PAUSE_WAIT, GRANT, RELEASE} state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [WW-1:0] wd_cnt;
  logic          lockout;
  logic          rd_acc;
  logic          vbl_ok;
  logic          wd_expired;
  logic          hs_stay;

  assign vbl_ok     = (USE_VBLANK == 0) || vblank;
  assign wd_expired = (wd_cnt == WW'(MAX_GRANT - 1));
  // The last GRANT cycle (request dropped or watchdog expiry) forwards no access.
  assign hs_stay    = hs_req && !wd_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      wd_cnt     <= '0;
      lockout    <= 1'b0;
      rd_acc     <= 1'b0;
      hs_gnt     <= 1'b0;
      hs_rvalid  <= 1'b0;
      hs_abort   <= 1'b0;
      pause_cpu  <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
    end else begin
      hs_abort  <= 1'b0;
      rd_acc    <= 1'b0;
      // Read issued on ram_addr last cycle; the RAM returns it now.
      hs_rvalid <= rd_acc;
      case (state)
        IDLE: begin
          ram_addr <= cpu_addr;
          ram_din  <= cpu_dout;
          ram_we   <= cpu_we;
          if (!hs_req) begin
            lockout <= 1'b0;
          end else if (!lockout && vbl_ok) begin
            pause_cpu  <= 1'b1;
            settle_cnt <= SW'(SETTLE);
            state      <= PAUSE_WAIT;
          end
        end
        PAUSE_WAIT: begin
          ram_we <= 1'b0;
          if (!hs_req) begin
            pause_cpu <= 1'b0;
            state     <= IDLE;
          end else if (settle_cnt == '0) begin
            hs_gnt <= 1'b1;
            wd_cnt <= '0;
            state  <= GRANT;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        GRANT: begin
          if (hs_stay) begin
            ram_addr <= hs_addr;
            ram_din  <= hs_dout;
            ram_we   <= hs_we;
            rd_acc   <= hs_rd && !hs_we;
            wd_cnt   <= wd_cnt + WW'(1);
          end else begin
            hs_gnt <= 1'b0;
            ram_we <= 1'b0;
            state  <= RELEASE;
            if (hs_req) begin
              hs_abort <= 1'b1;
              lockout  <= 1'b1;
            end
          end
        end
        RELEASE: begin
          ram_we    <= 1'b0;
          pause_cpu <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: directed scenarios plus randomized sessions against a memory/timing reference.
module tb_hiscore_ram_arbiter;

  localparam int AW         = 12;
  localparam int SETTLE     = 4;
  localparam int MAX_GRANT  = 8;
  localparam int USE_VBLANK = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vblank = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_dout = '0;
  logic          cpu_we = 1'b0;
  logic          hs_req = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [7:0]    hs_dout = '0;
  logic          hs_we = 1'b0;
  logic          hs_rd = 1'b0;
  logic          hs_gnt, hs_rvalid, hs_abort, pause_cpu, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;

  logic [7:0]    ram_mem [0:(1<<AW)-1];
  logic [7:0]    ram_q;
  logic [7:0]    ref_mem [0:31];

  int checks = 0;
  int errors = 0;

  hiscore_ram_arbiter #(
    .AW(AW), .SETTLE(SETTLE), .MAX_GRANT(MAX_GRANT), .USE_VBLANK(USE_VBLANK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_dout(hs_dout), .hs_we(hs_we), .hs_rd(hs_rd),
    .hs_gnt(hs_gnt), .hs_rvalid(hs_rvalid), .hs_abort(hs_abort), .pause_cpu(pause_cpu),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // Work RAM with 1-cycle registered read, cleared on reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_q <= ram_mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({hs_gnt, hs_rvalid, hs_abort, pause_cpu, ram_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got gnt/rv/abort/pause/we=%b want 00000",
               {hs_gnt, hs_rvalid, hs_abort, pause_cpu, ram_we});
    end
    checks++;
    if (ram_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_ram_addr got %h want 000", ram_addr);
    end
    checks++;
    if (ram_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_ram_din got %h want 00", ram_din);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    cpu_we = 1'b1; cpu_addr = 12'h055; cpu_dout = 8'hA5;
    tick();
    cpu_we = 1'b0;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 12'h055, 8'hA5}) begin
      errors++;
      $display("FAIL reset_cpu_path got we=%b addr=%h din=%h want 1 055 a5", ram_we, ram_addr, ram_din);
    end
  endtask

  task automatic test_grant_timing();
    vblank = 1'b1;
    hs_req = 1'b1;
    hs_we = 1'b1; hs_addr = 12'h0C0; hs_dout = 8'h11;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      tick();
      checks++;
      if ({pause_cpu, hs_gnt, ram_we} !== {1'b1, (k == SETTLE + 2), 1'b0}) begin
        errors++;
        $display("FAIL grant_timing cycle %0d got pause/gnt/we=%b%b%b want 1%b0",
                 k, pause_cpu, hs_gnt, ram_we, (k == SETTLE + 2));
      end
      cpu_we = (k <= 5); cpu_addr = 12'h123; cpu_dout = 8'hEE;
      if (k == SETTLE + 2) hs_we = 1'b0;
    end
    checks++;
    if (ram_mem[12'h123] !== 8'h00) begin
      errors++;
      $display("FAIL paused_cpu_write got mem[123]=%h want 00", ram_mem[12'h123]);
    end
  endtask

  task automatic test_write_read();
    hs_we = 1'b1; hs_addr = 12'h0B0; hs_dout = 8'h5A;
    tick();
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 12'h0B0, 8'h5A}) begin
      errors++;
      $display("FAIL hs_write got we=%b addr=%h din=%h want 1 0b0 5a", ram_we, ram_addr, ram_din);
    end
    hs_we = 1'b0; hs_rd = 1'b1;
    tick();
    hs_rd = 1'b0;
    checks++;
    if (hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL hs_read_early got rvalid=%b want 0", hs_rvalid);
    end
    tick();
    checks++;
    if ({hs_rvalid, ram_q} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL hs_read got rvalid=%b q=%h want 1 5a", hs_rvalid, ram_q);
    end
    hs_we = 1'b1; hs_rd = 1'b1; hs_addr = 12'h0B1; hs_dout = 8'h3C;
    tick();
    hs_we = 1'b0; hs_rd = 1'b0;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL we_rd_collision_write got we=%b want 1", ram_we);
    end
    tick();
    checks++;
    if (hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL we_rd_collision_rvalid got %b want 0", hs_rvalid);
    end
  endtask

  task automatic test_release();
    hs_req = 1'b0;
    tick();
    checks++;
    if ({hs_gnt, pause_cpu, hs_abort} !== 3'b010) begin
      errors++;
      $display("FAIL release_1 got gnt/pause/abort=%b want 010", {hs_gnt, pause_cpu, hs_abort});
    end
    tick();
    checks++;
    if (pause_cpu !== 1'b0) begin
      errors++;
      $display("FAIL release_2 got pause=%b want 0", pause_cpu);
    end
    cpu_we = 1'b1; cpu_addr = 12'h010; cpu_dout = 8'h77;
    tick();
    cpu_we = 1'b0;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 12'h010, 8'h77}) begin
      errors++;
      $display("FAIL release_cpu_write got we=%b addr=%h din=%h want 1 010 77", ram_we, ram_addr, ram_din);
    end
  endtask

  task automatic test_watchdog();
    int gnt_cycles = 0;
    int abort_cnt = 0;
    int pause_cycles = 0;
    int abort_at = -1;
    int last_gnt = -1;
    hs_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (hs_gnt) begin gnt_cycles++; last_gnt = c; end
      if (hs_abort) begin abort_cnt++; abort_at = c; end
      if (pause_cpu) pause_cycles++;
    end
    checks++;
    if (gnt_cycles != MAX_GRANT) begin
      errors++;
      $display("FAIL wd_grant_len got %0d want %0d", gnt_cycles, MAX_GRANT);
    end
    checks++;
    if (abort_cnt != 1 || abort_at != last_gnt + 1) begin
      errors++;
      $display("FAIL wd_abort got pulses=%0d at %0d want 1 at %0d", abort_cnt, abort_at, last_gnt + 1);
    end
    checks++;
    if (pause_cycles != SETTLE + 1 + MAX_GRANT + 1) begin
      errors++;
      $display("FAIL wd_lockout got pause_cycles=%0d want %0d", pause_cycles, SETTLE + MAX_GRANT + 2);
    end
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    for (int t = 1; t <= SETTLE + 2; t++) tick();
    checks++;
    if (hs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wd_regrant got gnt=%b want 1", hs_gnt);
    end
    hs_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_vblank();
    int pauses = 0;
    vblank = 1'b0;
    hs_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (pause_cpu) pauses++;
    end
    checks++;
    if (pauses != 0) begin
      errors++;
      $display("FAIL vblank_gate got %0d paused cycles want 0", pauses);
    end
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin
      errors++;
      $display("FAIL vblank_entry got pause=%b want 1", pause_cpu);
    end
    for (int t = 0; t < SETTLE + 1; t++) tick();
    checks++;
    if (hs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL vblank_drop_grant got gnt=%b want 1", hs_gnt);
    end
    hs_req = 1'b0;
    tick();
    tick();
    vblank = 1'b1;
  endtask

  task automatic test_random();
    int a, k, op;
    logic we, rd, p1_v, p2_v, exp_gnt, exp_pause;
    logic [7:0] p1_d, p2_d, rd_dat;
    logic [AW-1:0] exp_addr;
    logic [7:0] exp_din;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    vblank = 1'b1;
    for (int s = 0; s < 12; s++) begin
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        a = $urandom_range(0, 31);
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'(12'h200 + a); cpu_dout = 8'($urandom);
        if (cpu_we) ref_mem[a] = cpu_dout;
        we = cpu_we; exp_addr = cpu_addr; exp_din = cpu_dout;
        tick();
        checks++;
        if (ram_we !== we || (we && {ram_addr, ram_din} !== {exp_addr, exp_din})) begin
          errors++;
          $display("FAIL rnd_cpu s%0d got we=%b addr=%h din=%h want %b %h %h", s, ram_we, ram_addr, ram_din, we, exp_addr, exp_din);
        end
      end
      cpu_we = 1'b0;
      hs_req = 1'b1;
      for (int t = 1; t <= SETTLE + 2; t++) begin
        tick();
        checks++;
        if ({pause_cpu, hs_gnt, ram_we} !== {1'b1, (t == SETTLE + 2), 1'b0}) begin
          errors++;
          $display("FAIL rnd_pause s%0d t%0d got pause/gnt/we=%b%b%b", s, t, pause_cpu, hs_gnt, ram_we);
        end
        cpu_we = (t < SETTLE + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        cpu_addr = AW'(12'h200 + $urandom_range(0, 31)); cpu_dout = 8'($urandom);
      end
      k = $urandom_range(1, 5);
      p1_v = 1'b0; p1_d = 8'h00;
      for (int j = 0; j <= k + 1; j++) begin
        we = 1'b0; rd = 1'b0; rd_dat = 8'h00;
        if (j < k) begin
          op = $urandom_range(0, 3);
          a = $urandom_range(0, 31);
          we = op[0]; rd = op[1];
          hs_addr = AW'(12'h200 + a); hs_dout = 8'($urandom);
          if (we) ref_mem[a] = hs_dout;
          else rd_dat = ref_mem[a];
          hs_req = 1'b1;
        end else begin
          hs_req = 1'b0;
        end
        hs_we = we; hs_rd = rd;
        exp_addr = hs_addr; exp_din = hs_dout;
        p2_v = p1_v; p2_d = p1_d;
        p1_v = rd && !we; p1_d = rd_dat;
        tick();
        exp_gnt = (j < k); exp_pause = (j <= k);
        checks++;
        if ({hs_gnt, pause_cpu} !== {exp_gnt, exp_pause}) begin
          errors++;
          $display("FAIL rnd_gnt s%0d j%0d got gnt/pause=%b%b want %b%b", s, j, hs_gnt, pause_cpu, exp_gnt, exp_pause);
        end
        checks++;
        if (ram_we !== we || (we && {ram_addr, ram_din} !== {exp_addr, exp_din})) begin
          errors++;
          $display("FAIL rnd_hs_write s%0d j%0d got we=%b addr=%h din=%h want %b %h %h", s, j, ram_we, ram_addr, ram_din, we, exp_addr, exp_din);
        end
        checks++;
        if (hs_rvalid !== p2_v || (p2_v && ram_q !== p2_d)) begin
          errors++;
          $display("FAIL rnd_read s%0d j%0d got rvalid=%b q=%h want %b %h", s, j, hs_rvalid, ram_q, p2_v, p2_d);
        end
      end
      hs_we = 1'b0; hs_rd = 1'b0;
    end
  endtask

  task automatic test_reset_mid_grant();
    hs_req = 1'b1;
    for (int t = 1; t <= SETTLE + 2; t++) tick();
    checks++;
    if (hs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant got gnt=%b want 1", hs_gnt);
    end
    hs_we = 1'b1; hs_addr = 12'h300; hs_dout = 8'h99;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, hs_gnt, pause_cpu} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async got we/gnt/pause=%b want 000", {ram_we, hs_gnt, pause_cpu});
    end
    hs_req = 1'b0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({ram_we, hs_gnt, pause_cpu} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_after got we/gnt/pause=%b want 000", {ram_we, hs_gnt, pause_cpu});
    end
    hs_we = 1'b0;
    cpu_we = 1'b1; cpu_addr = 12'h020; cpu_dout = 8'h31;
    tick();
    cpu_we = 1'b0;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 12'h020, 8'h31}) begin
      errors++;
      $display("FAIL midrst_cpu_owns got we=%b addr=%h din=%h want 1 020 31", ram_we, ram_addr, ram_din);
    end
  endtask

  initial begin
    test_reset();
    test_grant_timing();
    test_write_read();
    test_release();
    test_watchdog();
    test_vblank();
    test_random();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
